// File: rtl/button_pkg.sv
// Shared defaults, repeat FSM state type and counter sizing helper for the
// button conditioner.
package button_pkg;

  localparam int unsigned CHANNELS_DEF        = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 650_000;
  localparam int unsigned HOLD_CYCLES_DEF     = 40_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF   = 10_000_000;
  localparam int unsigned REPEAT_EN_DEF       = 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    REPEAT
  } rpt_state_e;

  // Counter width for a compare-and-clear counter reaching n-1; at least 1 bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? int'($clog2(n)) : 1;
    return w;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-FF synchroniser, symmetric debouncer and optional
// auto-repeat FSM producing level, press, release and repeat strobes.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int unsigned REPEAT_EN       = REPEAT_EN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  localparam int unsigned DEB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             accept_rise, accept_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      deb_cnt_q <= '0;
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Counter runs only while the synchronised input disagrees with the level;
  // any agreement restarts the stability window.
  always_comb begin
    level_d   = level_q;
    deb_cnt_d = '0;
    if (sync2_q != level_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        level_d = ~level_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
    accept_rise = level_d & ~level_q;
    accept_fall = ~level_d & level_q;
    press_d     = accept_rise;
    release_d   = accept_fall;
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

  if (REPEAT_EN != 0) begin : g_repeat
    localparam int unsigned RPT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned RPT_W   = cnt_width(RPT_MAX);
    localparam logic [RPT_W-1:0] HOLD_LAST = RPT_W'(HOLD_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST  = RPT_W'(REPEAT_CYCLES - 1);

    rpt_state_e       state_q, state_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             repeat_q, repeat_d;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= IDLE;
        rpt_cnt_q <= '0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
        repeat_q  <= repeat_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      unique case (state_q)
        IDLE: begin
          rpt_cnt_d = '0;
          if (accept_rise) state_d = HOLD;
        end
        HOLD: begin
          if (rpt_cnt_q == HOLD_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
            state_d   = REPEAT;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (rpt_cnt_q == RPT_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          rpt_cnt_d = '0;
        end
      endcase
      // Release overrides everything, including a repeat due in the same cycle.
      if (accept_fall) begin
        state_d   = IDLE;
        rpt_cnt_d = '0;
        repeat_d  = 1'b0;
      end
    end

    assign btn_repeat = repeat_q;
  end else begin : g_no_repeat
    assign btn_repeat = 1'b0;
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: one independent button_channel per pin,
// the top level only fans bits in and out.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned CHANNELS        = CHANNELS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
  parameter int unsigned REPEAT_EN       = REPEAT_EN_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_repeat
);

  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("button_conditioner: CHANNELS must be in 1..16");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("button_conditioner: HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_CYCLES must be >= 1");
  end
  if (REPEAT_EN > 1) begin : g_bad_repeat_en
    $error("button_conditioner: REPEAT_EN must be 0 or 1");
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .REPEAT_EN       (REPEAT_EN)
    ) u_channel (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_repeat  (btn_repeat[i])
    );
  end

endmodule
